regfile_multiport: RTL and testbench

- Parametrised successor register file: configurable depth, N synchronous read ports, one byte-enabled write port.
- Optional hardwired-zero entry 0.
- Hardware clear sequencer on reset; ready flag gates use.
- Sits in the datapath as the general-purpose register store; feeds operand muxes, written from writeback.

---
 rtl/regfile_multiport.sv | 120 ++++++++++++
 tb/tb_regfile_multiport.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multiport register file with byte-enabled write, optional hardwired-zero entry 0
// and a clear sequencer after reset. REGFILE_BYPASS_EN selects write-first reads.
module regfile_multiport #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           write_En,
  input  logic [ADDR_WIDTH-1:0]          write_Addr,
  input  logic [DATA_WIDTH/8-1:0]        write_Be,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_Rd,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
  output logic                           ready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
  logic [0:0]                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]          clr_ptr_q, clr_ptr_d;
  logic                           ready_q, ready_d;
  logic [NUM_READ*DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  wr_live;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  // An address is live when it maps to a real, writable entry.
  function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
    addr_live = ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NBYTES-1:0]     be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NBYTES; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign wr_live   = write_En && (|write_Be) && addr_live(write_Addr);
  assign wr_merged = merge_bytes(mem_q[write_Addr], data_in, write_Be);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = write_Addr;
    mem_wdata = wr_merged;
    rd_addr   = '0;
    rd_word   = '0;
    if (state_q == ST_CLEAR) begin
      mem_we    = !Rst;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
      clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
      dout_d    = '0;
      if (clr_ptr_q == LAST_IDX) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    end else begin
      mem_we = wr_live && !Rst;
      // Reads see the pre-edge array unless write-first forwarding is built in.
      for (int i = 0; i < NUM_READ; i++) begin
        rd_addr = addr_Rd[i*ADDR_WIDTH +: ADDR_WIDTH];
        rd_word = addr_live(rd_addr) ? mem_q[rd_addr] : '0;
        if (BYPASS && wr_live && (rd_addr == write_Addr)) rd_word = wr_merged;
        dout_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_word;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      dout_q    <= dout_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_out = dout_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: DEPTH=32 and DEPTH=20 instances share stimulus and
// are checked against an array-based model of the register file behaviour.
module tb_regfile_multiport;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [7:0]    be = '0;
  logic [DW-1:0] din = '0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] dout32, dout20;
  logic rdy32, rdy20;

  regfile_multiport #(.DATA_WIDTH(DW), .DEPTH(32), .NUM_READ(NR), .ZERO_REG(1)) dut32 (
    .Clk(clk), .Rst(rst), .write_En(we), .write_Addr(wa), .write_Be(be),
    .data_in(din), .addr_Rd(ra), .data_out(dout32), .ready(rdy32));

  regfile_multiport #(.DATA_WIDTH(DW), .DEPTH(20), .NUM_READ(NR), .ZERO_REG(1)) dut20 (
    .Clk(clk), .Rst(rst), .write_En(we), .write_Addr(wa), .write_Be(be),
    .data_in(din), .addr_Rd(ra), .data_out(dout20), .ready(rdy20));

  int            depth_of [2];
  logic [DW-1:0] mdl [2][32];
  int            edges [2];
  logic [NR*DW-1:0] exp_dout [2];
  logic          exp_rdy [2];
  logic [NR*DW-1:0] dout_w [2];
  logic          rdy_w [2];
  int errors = 0;
  int checks = 0;

  assign dout_w[0] = dout32;
  assign dout_w[1] = dout20;
  assign rdy_w[0]  = rdy32;
  assign rdy_w[1]  = rdy20;

  // One rising edge: update the model from the stable inputs, then settle to the falling edge.
  task automatic tick();
    logic [DW-1:0] oldv, newv, v;
    int dep, rad, wad;
    bit wok;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      dep = depth_of[d];
      if (rst) begin
        edges[d] = 0;
        exp_dout[d] = '0;
        exp_rdy[d] = 1'b0;
      end else if (edges[d] < dep) begin
        mdl[d][edges[d]] = '0;
        edges[d]++;
        exp_dout[d] = '0;
        exp_rdy[d] = (edges[d] >= dep);
      end else begin
        wad  = int'(wa);
        wok  = we && (wad != 0) && (wad < dep);
        oldv = (wad < dep) ? mdl[d][wad] : '0;
        for (int k = 0; k < 8; k++) newv[8*k +: 8] = be[k] ? din[8*k +: 8] : oldv[8*k +: 8];
        for (int p = 0; p < NR; p++) begin
          rad = int'(ra[p*AW +: AW]);
          v = (rad == 0 || rad >= dep) ? '0 : mdl[d][rad];
          if (BYP && wok && rad == wad) v = newv;
          exp_dout[d][p*DW +: DW] = v;
        end
        if (wok) mdl[d][wad] = newv;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; ra = '0;
    repeat (3) begin
      tick();
      checks++;
      if (rdy32 !== 1'b0 || rdy20 !== 1'b0 || dout32 !== '0 || dout20 !== '0) begin
        errors++;
        $display("FAIL reset: rdy32=%b rdy20=%b dout32=%h dout20=%h required rdy=0 dout=0",
                 rdy32, rdy20, dout32, dout20);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      we  = (k < 20);
      wa  = AW'($urandom_range(31, 1));
      din = {$urandom, $urandom};
      be  = 8'hFF;
      ra  = {AW'($urandom_range(31)), AW'($urandom_range(31))};
      tick();
      checks++;
      if (rdy32 !== (k == 31) || rdy20 !== (k >= 19) || dout32 !== '0) begin
        errors++;
        $display("FAIL clear_ready edge %0d: rdy32=%b rdy20=%b dout32=%h required rdy32=%b rdy20=%b dout32=0",
                 k + 1, rdy32, rdy20, dout32, k == 31, k >= 19);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_clear_contents();
    for (int a = 0; a < 32; a += 2) begin
      ra = {AW'(a + 1), AW'(a)};
      tick();
      checks++;
      if (dout32 !== '0 || dout20 !== '0) begin
        errors++;
        $display("FAIL cleared_entries %0d/%0d: dout32=%h dout20=%h required 0", a, a + 1, dout32, dout20);
      end
    end
  endtask

  task automatic test_partial_write();
    we = 1'b1; wa = 5'd5; din = 64'h1122334455667788; be = 8'hFF; ra = '0;
    tick();
    we = 1'b0; ra = {5'd0, 5'd5};
    tick();
    checks++;
    if (dout32[63:0] !== 64'h1122334455667788 || dout20[63:0] !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL full_write: dout32=%h dout20=%h required 1122334455667788", dout32[63:0], dout20[63:0]);
    end
    we = 1'b1; din = '1; be = 8'h0F;
    tick();
    we = 1'b0;
    tick();
    checks++;
    if (dout32[63:0] !== 64'h11223344FFFFFFFF || dout20[63:0] !== 64'h11223344FFFFFFFF) begin
      errors++;
      $display("FAIL byte_enable: dout32=%h dout20=%h required 11223344ffffffff", dout32[63:0], dout20[63:0]);
    end
    we = 1'b1; wa = 5'd0; din = {$urandom, $urandom} | 64'h1; be = 8'hFF; ra = {5'd0, 5'd0};
    tick();
    we = 1'b0;
    tick();
    checks++;
    if (dout32[127:64] !== '0 || dout20[127:64] !== '0) begin
      errors++;
      $display("FAIL zero_reg: port1 dout32=%h dout20=%h required 0", dout32[127:64], dout20[127:64]);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] aa, first;
    aa = {8{8'hAA}};
    first = BYP ? aa : '0;
    we = 1'b1; wa = 5'd7; din = aa; be = 8'hFF; ra = {5'd7, 5'd7};
    tick();
    checks++;
    if (dout32 !== {first, first} || dout20 !== {first, first}) begin
      errors++;
      $display("FAIL same_cycle: dout32=%h dout20=%h required both ports %h", dout32, dout20, first);
    end
    we = 1'b0;
    tick();
    checks++;
    if (dout32 !== {aa, aa} || dout20 !== {aa, aa}) begin
      errors++;
      $display("FAIL after_write: dout32=%h dout20=%h required both ports %h", dout32, dout20, aa);
    end
  endtask

  task automatic test_out_of_range();
    we = 1'b1; wa = 5'd25; din = {$urandom, $urandom} | 64'h1; be = 8'hFF; ra = {5'd25, 5'd25};
    tick();
    we = 1'b0;
    tick();
    checks++;
    if (dout20 !== '0 || dout32 !== exp_dout[0]) begin
      errors++;
      $display("FAIL out_of_range: dout20=%h dout32=%h required dout20=0 dout32=%h", dout20, dout32, exp_dout[0]);
    end
    ra = {5'd9, 5'd5};
    tick();
    checks++;
    if (dout20 !== {64'h0, 64'h11223344FFFFFFFF}) begin
      errors++;
      $display("FAIL no_alias: dout20=%h required %h", dout20, {64'h0, 64'h11223344FFFFFFFF});
    end
  endtask

  task automatic test_midclear();
    int rise32, rise20;
    we = 1'b0; ra = '0;
    rst = 1'b1; tick();
    rst = 1'b0; repeat (10) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    rise32 = -1; rise20 = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (rdy32 === 1'b1 && rise32 < 0) rise32 = n;
      if (rdy20 === 1'b1 && rise20 < 0) rise20 = n;
    end
    checks++;
    if (rise32 != 32 || rise20 != 20) begin
      errors++;
      $display("FAIL midclear_restart: ready rose at edge %0d/%0d (-1 = never) required 32/20", rise32, rise20);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(3) != 0);
      wa  = AW'($urandom_range(31));
      din = {$urandom, $urandom};
      be  = 8'($urandom);
      ra  = {AW'($urandom_range(31)), AW'($urandom_range(31))};
      if ($urandom_range(3) == 0) ra[AW-1:0] = wa;
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (dout_w[d] !== exp_dout[d] || rdy_w[d] !== exp_rdy[d]) begin
          errors++;
          $display("FAIL random depth=%0d cycle %0d: dout=%h rdy=%b required dout=%h rdy=%b",
                   depth_of[d], n, dout_w[d], rdy_w[d], exp_dout[d], exp_rdy[d]);
        end
      end
    end
    we = 1'b0;
  endtask

  initial begin
    depth_of[0] = 32;
    depth_of[1] = 20;
    for (int d = 0; d < 2; d++) begin
      edges[d] = 0;
      exp_dout[d] = '0;
      exp_rdy[d] = 1'b0;
      for (int a = 0; a < 32; a++) mdl[d][a] = '0;
    end
    test_reset();
    test_clear_contents();
    test_partial_write();
    test_same_cycle();
    test_out_of_range();
    test_midclear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
